// File: rtl/cpu_io_pkg.sv
// Shared types and constants for the core's byte-output path.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package cpu_io_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int UART_DATA_BITS       = 8;
    localparam int UART_FRAME_BITS      = 10;
    localparam int DEFAULT_CLKS_PER_BIT = 434;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO; head is read combinationally from the registered read pointer.
// Latency: a pushed entry is visible at the head (empty=0) one edge after the push.
// Backpressure: pushes while full are ignored; pops while empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    // A full FIFO refuses the push even when a pop happens on the same edge.
    assign push_ok   = push & ~full;
    assign pop_ok    = pop & ~empty;
    assign head_data = mem_q[rd_ptr_q];
    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(DEPTH));
    assign count     = count_q;

    // Next pointer/occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care after reset because the count is cleared.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/out_uart_tx.sv
// Buffers core output bytes and serialises them as UART 8N1, LSB first.
// Latency: byte written at edge E into an idle, empty block is popped at E+1; tx falls at E+2.
// Backpressure: out_full (registered) tells the core to hold off; a write while full is dropped and sets sticky overflow.
module out_uart_tx
    import cpu_io_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       out_en,
    input  logic [7:0] out_data,
    output logic       out_full,
    output logic       tx,
    output logic       busy,
    output logic       overflow
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = $clog2(UART_DATA_BITS);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(UART_DATA_BITS - 1);

    logic [7:0]       fifo_head;
    logic             fifo_empty;
    logic             fifo_full;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_pop;
    logic             push_ok;

    tx_state_t        state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             overflow_q, overflow_d;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (out_en),
        .push_data (out_data),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    assign push_ok  = out_en & ~fifo_full;
    assign out_full = fifo_full;
    assign tx       = tx_q;
    assign busy     = busy_q;
    assign overflow = overflow_q;

    // Frame sequencer: next state, baud/bit counters, shift register and FIFO pop.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        fifo_pop = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_head;
                    baud_d   = '0;
                    state_d  = START;
                end
            end
            START: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == BIT_LAST) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            STOP: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    state_d = IDLE;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Registered line level follows the current state, so tx trails the state by one cycle.
    always_comb begin
        case (state_q)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_q[0];
            default: tx_d = 1'b1;
        endcase
    end

    // busy tracks the tx lag: it rises with the write and falls as the stop bit ends; overflow is sticky.
    always_comb begin
        busy_d     = (state_q != IDLE) || (fifo_count != '0) || push_ok;
        overflow_d = overflow_q | (out_en & fifo_full);
    end

    // All sequencer and output registers; reset forces the line idle and truncates any frame.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_out_uart_tx.sv
// Scoreboard bench for out_uart_tx: a UART receiver model decodes tx and compares against queued bytes.
// Latency: checks pop/start timing and frame period at CLKS_PER_BIT=4.
// Backpressure: exercises overflow drops and a core model that honours out_full.
module tb_out_uart_tx;
    import cpu_io_pkg::*;

    localparam int C = 4;
    localparam int D = 16;

    logic       clock;
    logic       reset_n;
    logic       out_en;
    logic [7:0] out_data;
    logic       out_full;
    logic       tx;
    logic       busy;
    logic       overflow;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc   = 0;
    logic [7:0]  exp_q[$];
    int          start_q[$];

    out_uart_tx #(
        .CLKS_PER_BIT (C),
        .FIFO_DEPTH   (D)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .out_en   (out_en),
        .out_data (out_data),
        .out_full (out_full),
        .tx       (tx),
        .busy     (busy),
        .overflow (overflow)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic mon_wait(input int n, inout bit ab);
        repeat (n) begin
            @(negedge clock);
            if (reset_n !== 1'b1) ab = 1'b1;
        end
    endtask

    // Receiver model: sample each bit in its middle, decode LSB-first, compare with the oldest expected byte.
    initial begin : monitor
        bit         ab;
        logic [7:0] b;
        logic       st;
        logic       sp;
        logic [7:0] e;
        forever begin
            @(negedge clock);
            if (reset_n === 1'b1 && tx === 1'b0) begin
                start_q.push_back(cyc);
                ab = 1'b0;
                mon_wait(C / 2, ab);
                st = tx;
                for (int i = 0; i < UART_DATA_BITS; i++) begin
                    mon_wait(C, ab);
                    b[i] = tx;
                end
                mon_wait(C, ab);
                sp = tx;
                if (!ab) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected frame: got 0x%0h, expected no frame", b);
                    end else begin
                        e = exp_q.pop_front();
                        check("rx byte", {24'd0, b}, {24'd0, e});
                        check("start bit", {31'd0, st}, 32'd0);
                        check("stop bit", {31'd0, sp}, 32'd1);
                    end
                end
            end
        end
    end

    // One strobe cycle; returns at the negedge after the write edge.
    task automatic send(input logic [7:0] b);
        out_en   = 1'b1;
        out_data = b;
        exp_q.push_back(b);
        @(negedge clock);
        out_en   = 1'b0;
    endtask

    task automatic drain(input int budget, input string name);
        int t;
        t = 0;
        repeat (3) @(negedge clock);
        while ((busy !== 1'b0 || exp_q.size() != 0) && t < budget) begin
            @(negedge clock);
            t++;
        end
        check({name, " drained in budget"}, {31'd0, (t < budget)}, 32'd1);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        check("reset tx", {31'd0, tx}, 32'd1);
        check("reset out_full", {31'd0, out_full}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset overflow", {31'd0, overflow}, 32'd0);
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    initial begin : stim
        int e0;
        int t;
        int gap;
        reset_n  = 1'b0;
        out_en   = 1'b0;
        out_data = 8'h00;
        @(negedge clock);
        do_reset();

        // Single byte: latency and bit pattern.
        start_q.delete();
        send(8'h41);
        e0 = cyc;
        check("tx still idle at E+1", {31'd0, tx}, 32'd1);
        drain(100, "single");
        check("single frames seen", start_q.size(), 32'd1);
        if (start_q.size() > 0) check("start latency", start_q[0] - e0, 32'd2);
        check("single overflow", {31'd0, overflow}, 32'd0);

        // Back-to-back: simultaneous push/pop at count=1, then exact frame period.
        start_q.delete();
        send(8'h55);
        send(8'hAA);
        check("count after push+pop", {27'd0, dut.u_fifo.count_q}, 32'd1);
        check("busy after writes", {31'd0, busy}, 32'd1);
        drain(200, "b2b");
        check("b2b frames seen", start_q.size(), 32'd2);
        if (start_q.size() > 1)
            check("frame period", start_q[1] - start_q[0], UART_FRAME_BITS * C + 1);

        // Burst fill: 18 consecutive writes, 17th fills, 18th dropped.
        for (int k = 0; k < 18; k++) begin
            out_en   = 1'b1;
            out_data = 8'(k);
            if (k < 17) exp_q.push_back(8'(k));
            @(negedge clock);
            if (k == 15) check("out_full before last free", {31'd0, out_full}, 32'd0);
            if (k == 16) begin
                check("out_full at 17th write", {31'd0, out_full}, 32'd1);
                check("overflow before drop", {31'd0, overflow}, 32'd0);
            end
            if (k == 17) check("overflow after drop", {31'd0, overflow}, 32'd1);
        end
        out_en = 1'b0;
        drain(1000, "burst");
        check("overflow sticky", {31'd0, overflow}, 32'd1);

        do_reset();

        // Stall compliance: random bytes and gaps, core holds off while out_full.
        for (int i = 0; i < 40; i++) begin
            gap = int'($urandom_range(0, 2));
            repeat (gap) @(negedge clock);
            t = 0;
            while (out_full === 1'b1 && t < 200) begin
                @(negedge clock);
                t++;
            end
            if (t >= 200) check("stall wait expired", 32'd1, 32'd0);
            send(8'($urandom));
        end
        drain(40 * (UART_FRAME_BITS * C + 1) + 200, "stall");
        check("stall overflow", {31'd0, overflow}, 32'd0);
        check("stall busy", {31'd0, busy}, 32'd0);

        // Reset mid-frame during data bit 3 of 0xC3 (bit 3 = 0).
        send(8'hC3);
        send(8'h99);
        repeat (18) @(negedge clock);
        check("tx at data bit 3", {31'd0, tx}, 32'd0);
        #2;
        reset_n = 1'b0;
        #1;
        check("async reset tx", {31'd0, tx}, 32'd1);
        check("async reset busy", {31'd0, busy}, 32'd0);
        check("async reset fifo empty", {27'd0, dut.u_fifo.count_q}, 32'd0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        exp_q.delete();
        repeat (60) @(negedge clock);
        check("idle after reset", {31'd0, busy}, 32'd0);
        check("line high after reset", {31'd0, tx}, 32'd1);
        send(8'h7E);
        drain(100, "post reset");
        check("post reset overflow", {31'd0, overflow}, 32'd0);

        repeat (5) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/out_uart_tx.md
Name: out_uart_tx

Overview:
- Consumer end of the core's byte output stream (out_en / out_data, emitted on each '.' instruction).
- Buffers bytes in a small synchronous FIFO and serialises them onto a UART 8N1 line.
- Drives a stall flag back to the core so that programs printing faster than the line rate do not lose data.
- Sits beside core inside the cpu top, between core output and the board TX pin.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); legal range >= 2.
- FIFO_DEPTH, 16, FIFO entries; must be a power of two, >= 2.

Ports:
- clock  input  1  system clock; all state on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- out_en  input  1  core byte strobe; one byte per high cycle.
- out_data  input  8  byte from core, valid when out_en=1.
- out_full  output  1  FIFO full; core must hold off '.' while high.
- tx  output  1  UART serial line, idle high.
- busy  output  1  high while FIFO non-empty or a frame is in flight.
- overflow  output  1  sticky; set when a byte is dropped.

Behaviour:
- Reset (asynchronous, reset_n=0): tx=1, out_full=0, busy=0, overflow=0, FIFO empty, FSM in IDLE, bit and baud counters 0.
- Reset asserted mid-frame: tx returns to 1 immediately; the frame is truncated; FIFO contents are discarded.
- Write path:
  - out_en=1 and out_full=0: out_data is pushed at that edge.
  - out_en=1 and out_full=1: the byte is dropped and overflow is set. The drop happens even if a pop occurs in the same cycle, because out_full reflects the registered count.
- out_full = (count == FIFO_DEPTH), registered; goes high on the edge that writes the last free entry.
- Simultaneous push and pop on a non-full FIFO: the count is unchanged and both operations take effect.
- overflow is cleared only by reset.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If the FIFO is non-empty, pop the head into an 8-bit shift register, clear the baud counter, and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit, LSB first. Shift right after each bit. After bit index 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- tx is driven from a register (glitch-free).
- Latency: a byte written at edge E into an empty FIFO, with the FSM in IDLE, is popped at edge E+1; tx falls at edge E+2.
- Back-to-back frames: exactly one IDLE cycle between the end of STOP and the next START, so the frame period is 10*CLKS_PER_BIT+1 cycles.
- busy = (FSM != IDLE) or (count != 0), registered-equivalent; 0 only when fully drained.
- Pointers wrap modulo FIFO_DEPTH. The count is $clog2(FIFO_DEPTH)+1 bits wide and never exceeds FIFO_DEPTH.
- Baud counter runs 0..CLKS_PER_BIT-1; its width is $clog2(CLKS_PER_BIT).

Decomposition:
- Package cpu_io_pkg:
  - tx_state_t enum {IDLE, START, DATA, STOP}.
  - Constants UART_DATA_BITS=8 and UART_FRAME_BITS=10.
  - Default CLKS_PER_BIT value.
- Sub-module sync_fifo (parameters WIDTH, DEPTH):
  - Inputs: push, push_data, pop.
  - Outputs: head_data, empty, full, count.
  - Pop returns the head combinationally from the registered read pointer.
- out_uart_tx contains the overflow logic, the FSM, and the baud/bit counters.

Test Plan:
- Single byte, CLKS_PER_BIT=4: one out_en with 0x41. Required response:
  - tx low 2 cycles after the strobe edge.
  - Then bits 1,0,0,0,0,0,1,0 at 4 cycles each, then stop high for 4 cycles.
  - busy falls after the stop bit; overflow stays 0.
- Burst fill, FIFO_DEPTH=16, CLKS_PER_BIT=4: out_en held for 18 cycles with bytes 0x00..0x11. Required response:
  - First byte popped at cycle 1, so 16 bytes are buffered.
  - out_full rises at the 17th write; byte 0x11 is dropped and overflow=1.
  - Receiver model decodes 0x00..0x10 in order.
- Back-to-back: 0x55 then 0xAA on consecutive cycles → two frames separated by exactly one idle-high cycle; decoded 0x55, 0xAA.
- Stall compliance: the core model honours out_full while writing 40 bytes → all 40 decoded in order, overflow=0, busy=0 at the end.
- Reset mid-frame: reset_n low during DATA bit 3 → tx=1 asynchronously, busy=0, FIFO empty. After release, a new byte 0x7E transmits cleanly.
- Simultaneous push/pop at count=1: out_en on the same edge the FSM pops → count stays 1; no byte lost or duplicated.
